// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the single-clock and CDC FIFO family.
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

    // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DATA_WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
module fifo_regfile #(
    parameter int DATA_WIDTH = 37,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage is deliberately not reset; readers gate the output while empty.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock show-ahead FIFO with occupancy count, thresholds, flush and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 37,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic                          full,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    input  logic                          flush,
    input  logic                          clr_err,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    fifo_err_t             err_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [DATA_WIDTH-1:0] rdata_s;

    // Status flags decode straight from the count register so they track it with no lag.
    assign full         = (count_r == CNT_W'(DEPTH));
    assign empty        = (count_r == {CNT_W{1'b0}});
    assign almost_full  = (count_r >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_r <= CNT_W'(AE_LEVEL));
    assign count        = count_r;
    assign overflow     = err_r.overflow;
    assign underflow    = err_r.underflow;

    assign push_ok_s = push && !full && !flush;
    assign pop_ok_s  = pop && !empty && !flush;

    fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (push_ok_s),
        .waddr (wr_ptr_r),
        .wdata (din),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Show-ahead output: head entry while occupied, zero otherwise.
    always_comb begin
        if (empty) begin
            dout = {DATA_WIDTH{1'b0}};
        end else begin
            dout = rdata_s;
        end
    end

    // Pointer and occupancy update; flush outranks any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags: a new event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_r <= '{overflow: 1'b0, underflow: 1'b0};
        end else begin
            err_r.overflow  <= (push && full && !flush)  || (err_r.overflow  && !clr_err);
            err_r.underflow <= (pop  && empty && !flush) || (err_r.underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_sync_fifo_param;

    localparam int DW    = 37;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] din = '0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [DW-1:0] dout;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_err = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .push(push), .din(din), .full(full), .pop(pop),
        .dout(dout), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .flush(flush), .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Reference model: applies one clock edge's worth of the FIFO rules to the queue.
    task automatic model_step();
        int sz = mq.size();
        if (clr_err) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (push && sz == DEPTH && !flush) m_ovf = 1'b1;
        if (pop && sz == 0 && !flush) m_udf = 1'b1;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop && sz > 0) void'(mq.pop_front());
            if (push && sz < DEPTH) mq.push_back(din);
        end
    endtask

    task automatic check_all();
        int sz = mq.size();
        logic [DW-1:0] exp_dout;
        exp_dout = (sz > 0) ? mq[0] : '0;
        chk("count", 64'(count), 64'(sz));
        chk("dout", 64'(dout), 64'(exp_dout));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("full", 64'(full), 64'(sz == DEPTH));
        chk("almost_full", 64'(almost_full), 64'(sz >= DEPTH - 1));
        chk("almost_empty", 64'(almost_empty), 64'(sz <= 1));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_udf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit p, input logic [DW-1:0] d, input bit q);
        push = p;
        din  = d;
        pop  = q;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0);
        flush   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] got[$];
        int next_word;
        int cycles;

        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ae", 64'(almost_empty), 64'd1);
        chk("rst_af", 64'(almost_full), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        check_all();

        // Fill 0x01..0x04, then one overflowing push.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            tick();
            if (i == 1) begin
                chk("fill1_dout", 64'(dout), 64'h01);
                chk("fill1_count", 64'(count), 64'd1);
            end
            if (i == 3) chk("fill3_af", 64'(almost_full), 64'd1);
            if (i == 4) begin
                chk("fill4_full", 64'(full), 64'd1);
                chk("fill4_count", 64'(count), 64'd4);
            end
        end
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd4);

        // Drain in order, then one underflowing pop.
        for (int i = 1; i <= 4; i++) begin
            chk("drain_dout", 64'(dout), 64'(i));
            drive(1'b0, '0, 1'b1);
            tick();
        end
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_dout0", 64'(dout), 64'd0);
        tick();
        chk("udf_set", 64'(underflow), 64'd1);
        idle();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Simultaneous push/pop at count 2, then at full.
        drive(1'b1, DW'('h11), 1'b0); tick();
        drive(1'b1, DW'('h12), 1'b0); tick();
        drive(1'b1, DW'('h13), 1'b1); tick();
        chk("pp_count", 64'(count), 64'd2);
        chk("pp_dout", 64'(dout), 64'h12);
        drive(1'b1, DW'('h14), 1'b0); tick();
        drive(1'b1, DW'('h15), 1'b0); tick();
        drive(1'b1, DW'('h16), 1'b1); tick();
        chk("ppfull_count", 64'(count), 64'd3);
        chk("ppfull_ovf", 64'(overflow), 64'd1);
        chk("ppfull_dout", 64'(dout), 64'h13);
        idle();
        flush = 1'b1; clr_err = 1'b1;
        tick();
        idle();

        // Wrap stream 0x10..0x23 with a random pop duty.
        next_word = 'h10;
        cycles = 0;
        while ((got.size() < 20) && (cycles < 500)) begin
            bit p, q;
            p = (next_word <= 'h23) && (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            q = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            if (q) got.push_back(dout);
            drive(p, DW'(next_word), q);
            tick();
            if (p) next_word++;
            if (count > 3'd4) chk("wrap_count_bound", 64'(count), 64'd4);
            cycles++;
        end
        chk("wrap_done", 64'(got.size()), 64'd20);
        for (int i = 0; i < got.size(); i++) chk("wrap_order", 64'(got[i]), 64'('h10 + i));
        chk("wrap_ovf", 64'(overflow), 64'd0);
        chk("wrap_udf", 64'(underflow), 64'd0);
        idle();

        // Flush at count 3 with a push in the same cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'('h31 + i), 1'b0);
            tick();
        end
        drive(1'b1, DW'('h99), 1'b0);
        flush = 1'b1;
        tick();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_ovf", 64'(overflow), 64'd0);
        flush = 1'b0;
        drive(1'b1, DW'('hAA), 1'b0);
        tick();
        chk("post_flush_dout", 64'(dout), 64'hAA);

        // Build count=2 with overflow set, then assert reset between edges.
        drive(1'b1, DW'('hBB), 1'b0); tick();
        drive(1'b1, DW'('hCC), 1'b0); tick();
        drive(1'b1, DW'('hDD), 1'b0); tick();
        drive(1'b1, DW'('hEE), 1'b0); tick();
        drive(1'b0, '0, 1'b1); tick();
        tick();
        chk("pre_rst_count", 64'(count), 64'd2);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        idle();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_ovf", 64'(overflow), 64'd0);
        chk("arst_dout", 64'(dout), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        check_all();

        // clr_err together with a fresh overflow: set wins.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'('h40 + i), 1'b0);
            tick();
        end
        drive(1'b1, DW'('h50), 1'b0);
        clr_err = 1'b1;
        tick();
        chk("clr_vs_set_ovf", 64'(overflow), 64'd1);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO for buffering AXI-side channel payloads inside one clock domain.
- Generalises the team's 4-deep/37-bit CDC FIFO to arbitrary width and power-of-two depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Show-ahead read: head entry is always presented on dout while the FIFO is non-empty.

Parameters:
- DATA_WIDTH, 37, payload width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- push  in  1  write request
- din  in  DATA_WIDTH  write data
- full  out  1  count == DEPTH
- pop  in  1  read request
- dout  out  DATA_WIDTH  head entry; zero when empty
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- flush  in  1  synchronous discard of all entries
- clr_err  in  1  clears overflow/underflow
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rstn).
- Reset (rstn=0, async assert, sync release):
  - wr_ptr, rd_ptr and count clear to 0; overflow and underflow clear to 0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0, dout=0.
  - Storage array is not reset; dout is gated to zero while empty.
  - Reset mid-operation discards all contents immediately.
- Pointers: $clog2(DEPTH) bits each, natural wrap at DEPTH.
- count register: +1 on accepted push only, -1 on accepted pop only, unchanged when both are accepted.
- All status flags decode combinationally from the count register; no extra latency.
- Accept rules:
  - Push is accepted iff push && !full && !flush. Push while full is dropped, even if pop is asserted in the same cycle.
  - Pop is accepted iff pop && !empty && !flush. Pop while empty is ignored, even if push is asserted in the same cycle (no bypass).
  - Simultaneous accepted push and pop: both pointers advance, count is unchanged.
- Latency:
  - Data pushed at edge N appears on dout after edge N if the FIFO was empty. Write-to-read latency is 1 cycle.
  - After an accepted pop at edge N, dout shows the next entry after edge N.
- Flush has highest priority below reset:
  - Sets wr_ptr=rd_ptr=0 and count=0 at the next edge.
  - push/pop in the same cycle are discarded and do not set error flags.
- Error flags:
  - overflow sets on push && full && !flush; underflow sets on pop && empty && !flush.
  - Both hold until clr_err. If clr_err and a new event occur in the same cycle, set wins.
- Wrap-around: pointers roll DEPTH-1 -> 0 with no bubble. Data order is preserved across any number of wraps.
- Threshold edge cases:
  - AF_LEVEL=DEPTH makes almost_full equal to full.
  - AE_LEVEL=0 makes almost_empty equal to empty.

Decomposition:
- Package fifo_pkg:
  - function for pointer width from DEPTH.
  - localparam-style helpers for count width.
  - typedef for the error-flag struct {overflow, underflow}, reused by later FIFO variants.
- One sub-module, fifo_regfile:
  - DATA_WIDTH x DEPTH register array.
  - One synchronous write port, one asynchronous read port.
  - Shared with the CDC FIFO rewrite.
- Control (pointers, count, flags) stays in sync_fifo_param.

Test Plan:
- Reset then fill (DEPTH=4, DATA_WIDTH=37): push 0x01..0x04 on consecutive cycles.
  - After the 1st edge: dout=0x01, count=1.
  - After the 3rd edge: almost_full=1 (count=3).
  - After the 4th edge: full=1, count=4.
  - A 5th push with 0x05 sets overflow=1, and count stays 4.
- Drain: pop 4 times from full. dout sequence is 0x01,0x02,0x03,0x04, then empty=1 and dout=0. A 5th pop sets underflow=1.
- Simultaneous push/pop at count=2: count stays 2 and the order is preserved. Push/pop while full: push dropped, count becomes 3, overflow=1.
- Wrap: stream 20 words 0x10..0x23 with a random pop duty. The output order matches exactly, there are no errors, and count never exceeds 4.
- Flush at count=3 with push asserted: next cycle count=0, empty=1, no overflow. A subsequent push of 0xAA is read back as 0xAA.
- Async reset asserted mid-stream (count=2, overflow=1): outputs clear without a clock edge. Then clr_err with a simultaneous overflow event leaves overflow=1.
